// File: rtl/seg_scan_bcd.sv
// rtl/seg_scan_bcd.sv - binary to BCD converter (shift-add-3) driving a multiplexed seven-segment scan
module seg_scan_bcd #(
  parameter int N_DIG    = 8,
  parameter int BIN_W    = 16,
  parameter int SCAN_DIV = 50000
) (
  input  logic             clk1,
  input  logic             rst,
  input  logic             load,
  input  logic [BIN_W-1:0] bin_in,
  input  logic [N_DIG-1:0] dp_in,
  input  logic             lz_en,
  output logic             busy,
  output logic [N_DIG-1:0] dig,
  output logic [6:0]       seg,
  output logic             dp
);

  localparam int AW = 4 * N_DIG;
  localparam int CW = $clog2(BIN_W);
  localparam int IW = (N_DIG > 1) ? $clog2(N_DIG) : 1;
  localparam int PW = $clog2(SCAN_DIV);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_nxt;
  logic [BIN_W-1:0] data_q;
  logic [AW-1:0]    acc_q, acc_adj;
  logic             ovf_q;
  logic [CW-1:0]    cnt_q;
  logic [N_DIG-1:0] cap_dp_q;

  logic [AW-1:0]    disp_q;
  logic             disp_ovf_q;
  logic [N_DIG-1:0] disp_dp_q;

  logic [PW-1:0]    presc_q;
  logic [IW-1:0]    idx_q;

  logic [3:0]       nib;
  logic [6:0]       code;
  logic             blank;
  logic [N_DIG-1:0] dig_nxt;
  logic [6:0]       seg_nxt;
  logic             dp_nxt;

  always_ff @(posedge clk1) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (load) state_nxt = SHIFT;
      SHIFT:   if (cnt_q == '0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

  // Add-3 correction on every nibble before the shift keeps each nibble a valid BCD digit.
  always_comb begin
    acc_adj = acc_q;
    for (int i = 0; i < N_DIG; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      data_q     <= '0;
      acc_q      <= '0;
      ovf_q      <= 1'b0;
      cnt_q      <= '0;
      cap_dp_q   <= '0;
      disp_q     <= '0;
      disp_ovf_q <= 1'b0;
      disp_dp_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (load) begin
            data_q   <= bin_in;
            acc_q    <= '0;
            ovf_q    <= 1'b0;
            cnt_q    <= CW'(BIN_W - 1);
            cap_dp_q <= dp_in;
          end
        end
        SHIFT: begin
          {acc_q, data_q} <= {acc_adj, data_q} << 1;
          ovf_q           <= ovf_q | acc_adj[AW-1];
          cnt_q           <= cnt_q - CW'(1);
        end
        DONE: begin
          disp_q     <= acc_q;
          disp_ovf_q <= ovf_q;
          disp_dp_q  <= cap_dp_q;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      presc_q <= '0;
      idx_q   <= '0;
    end else if (presc_q == PW'(SCAN_DIV - 1)) begin
      presc_q <= '0;
      idx_q   <= (idx_q == IW'(N_DIG - 1)) ? '0 : idx_q + IW'(1);
    end else begin
      presc_q <= presc_q + PW'(1);
    end
  end

  always_comb begin
    nib = disp_q[4*idx_q +: 4];
    case (nib)
      4'd0:    code = 7'b1000000;
      4'd1:    code = 7'b1111001;
      4'd2:    code = 7'b0100100;
      4'd3:    code = 7'b0110000;
      4'd4:    code = 7'b0011001;
      4'd5:    code = 7'b0010010;
      4'd6:    code = 7'b0000010;
      4'd7:    code = 7'b1111000;
      4'd8:    code = 7'b0000000;
      4'd9:    code = 7'b0010000;
      default: code = 7'b1111111;
    endcase
    // A digit is a leading zero when it and every digit to its left are zero.
    blank   = lz_en && (idx_q != '0) && ((disp_q >> (4 * idx_q)) == '0);
    seg_nxt = disp_ovf_q ? 7'b0111111 : (blank ? 7'b1111111 : code);
    dp_nxt  = disp_ovf_q ? 1'b1 : ~disp_dp_q[idx_q];
    dig_nxt = ~(N_DIG'(1) << idx_q);
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      dig <= '1;
      seg <= 7'b1111111;
      dp  <= 1'b1;
    end else begin
      dig <= dig_nxt;
      seg <= seg_nxt;
      dp  <= dp_nxt;
    end
  end

endmodule

// File: doc/seg_scan_bcd.md
SEG_SCAN_BCD -- requirements
Module: seg_scan_bcd

Interface
REQ-001 Parameter N_DIG, default 8: number of multiplexed seven-segment digits, range 1..8.
REQ-002 Parameter BIN_W, default 16: binary input width, range 4..27.
REQ-003 Parameter SCAN_DIV, default 50000: clk1 cycles per digit dwell, minimum 2.
REQ-004 One clock; reset is synchronous and active-high. The clock port is clk1 and the reset port is rst.
REQ-005 clk1  in  1  system clock; all state on its rising edge.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 load  in  1  single-cycle request to convert bin_in.
REQ-008 bin_in  in  BIN_W  unsigned binary value to display.
REQ-009 dp_in  in  N_DIG  decimal point per digit, 1 = lit; captured with bin_in.
REQ-010 lz_en  in  1  1 = leading-zero blanking enabled; sampled live.
REQ-011 busy  out  1  high while a conversion is in progress.
REQ-012 dig  out  N_DIG  active-low digit select; bit i drives digit i, digit 0 rightmost.
REQ-013 seg  out  7  active-low segments {g,f,e,d,c,b,a}.
REQ-014 dp  out  1  active-low decimal point.

Function
REQ-015 Converter FSM states IDLE, SHIFT, DONE; busy = (state != IDLE).
REQ-016 IDLE: load=1 captures bin_in and dp_in, clears the 4*N_DIG-bit BCD accumulator and the overflow flag, loads the bit counter with BIN_W-1, and moves to SHIFT.
REQ-017 SHIFT, one bit per cycle, MSB first: each BCD nibble >= 5 gets +3, then {accumulator, data} shifts left 1; the counter decrements; at counter 0 the FSM moves to DONE.
REQ-018 A 1 shifted out of the accumulator MSB sets the sticky overflow flag.
REQ-019 DONE: copies the accumulator, overflow flag and captured dp to the display registers in one cycle, then returns to IDLE.
REQ-020 Latency: display registers update BIN_W+1 cycles after the load-accepting edge; busy is high for exactly BIN_W+1 cycles.
REQ-021 load while busy=1 (SHIFT or DONE) is ignored with no queuing; the display keeps its prior value until DONE.
REQ-022 Scan prescaler counts 0..SCAN_DIV-1 and wraps; each wrap advances the digit index 0..N_DIG-1, wrapping N_DIG-1 -> 0.
REQ-023 dig, seg and dp are registered and reflect the index and display registers with 1-cycle latency; exactly one dig bit is low outside reset.
REQ-024 Segment codes: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-025 Blanking: with lz_en=1, digit i>0 shows seg=1111111 when digits i..N_DIG-1 are all zero; digit 0 is never blanked.
REQ-026 Overflow: when the displayed overflow flag is 1, every digit shows dash 0111111 with dp off, regardless of lz_en.
REQ-027 dp output = ~captured_dp[index], except during overflow; a blanked digit still shows its decimal point.
REQ-028 The conversion and the scan run independently; a display register update mid-dwell takes effect on the next output register cycle.

Reset
REQ-029 rst=1 forces: state IDLE, busy 0, dig all 1s, seg 1111111, dp 1, display and accumulator 0, overflow 0, captured dp 0, index 0, prescaler 0.
REQ-030 rst takes priority over load; rst during SHIFT aborts the conversion and the display is zeroed.
REQ-031 After rst falls, the first scan output (dig bit 0 low, seg showing 0) appears one cycle later.

Verification
REQ-032 Reset check: assert rst for 3 cycles -> dig=11111111, seg=1111111, dp=1, busy=0; the cycle after release -> dig=11111110, seg=1000000.
REQ-033 Conversion with blanking: N_DIG=8, BIN_W=16, lz_en=1, load bin_in=1234 -> busy high for 17 cycles; digits 0..3 show 0011001, 0110000, 0100100, 1111001; digits 4..7 show 1111111.
REQ-034 Zero value: lz_en=1, bin_in=0 -> digit 0 shows 1000000, all other digits blank; with lz_en=0, all digits show 1000000.
REQ-035 Overflow: N_DIG=4, bin_in=12345 -> all four digits show 0111111 with dp=1; a following load of 999 -> 9,9,9 with digit 3 blank.
REQ-036 Busy and reset interaction: load 42, then load 77 on the next cycle -> 42 displayed and 77 ignored; load 77 after busy falls -> 77 displayed; rst asserted mid-SHIFT -> busy=0 and display 0 the next cycle.
REQ-037 Scan timing: SCAN_DIV=4, N_DIG=8 -> dig steps 11111110 through 01111111, each held 4 cycles, then wraps; dp_in=00000100 -> dp=0 only while dig=11111011.
